// File: rtl/bus_fifo_tostd_pkg.sv
// Shared sizing helpers for the bus_fifo_tostd elastic FIFO.
// The optional same-cycle bypass is enabled by defining BUS_FIFO_TOSTD_BYPASS_EN.
package bus_fifo_tostd_pkg;

  // Pointer width; a single-entry FIFO still needs a 1-bit pointer to index storage.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width, able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bus_fifo_tostd_wrap_ptr.sv
// Modulo-DEPTH pointer for bus_fifo_tostd; DEPTH need not be a power of two.
// Shared by the write and read sides. BUS_FIFO_TOSTD_BYPASS_EN does not affect this file.
module bus_fifo_tostd_wrap_ptr
  import bus_fifo_tostd_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PtrW  = ptr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  output logic [PtrW-1:0] ptr
);

  localparam logic [PtrW-1:0] Last = PtrW'(DEPTH - 1);

  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == Last) ? '0 : ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/bus_fifo_tostd.sv
// Elastic FIFO: hasAny/consume producer in, isReady/canReceive consumer out.
// Define BUS_FIFO_TOSTD_BYPASS_EN for a same-cycle fall-through path when empty.
module bus_fifo_tostd
  import bus_fifo_tostd_pkg::*;
#(
  parameter int unsigned BusSize = 1,
  parameter int unsigned DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BusSize-1:0]         i,
  input  logic                       i_hasAny,
  output logic                       i_consume,
  output logic [BusSize-1:0]         o,
  output logic                       o_isReady,
  input  logic                       o_canReceive,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PtrW = ptr_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [BusSize-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr, rd_ptr;
  logic [CntW-1:0]    count_q, count_d;
  logic               empty, full;
  logic               push, pop;
  logic [BusSize-1:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);
  assign head  = mem_q[rd_ptr];

  // Upstream handshake depends only on registered occupancy, never on o_canReceive.
  assign i_consume = ~rst & i_hasAny & ~full;

`ifdef BUS_FIFO_TOSTD_BYPASS_EN
  assign o         = empty ? i : head;
  assign o_isReady = ~rst & o_canReceive & (~empty | i_hasAny);
  // A word that falls straight through is never written into storage.
  assign push      = i_consume & ~(empty & o_canReceive);
  assign pop       = o_isReady & ~empty;
`else
  assign o         = head;
  assign o_isReady = ~rst & ~empty & o_canReceive;
  assign push      = i_consume;
  assign pop       = o_isReady;
`endif

  bus_fifo_tostd_wrap_ptr #(
    .DEPTH (DEPTH),
    .PtrW  (PtrW)
  ) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (push),
    .ptr     (wr_ptr)
  );

  bus_fifo_tostd_wrap_ptr #(
    .DEPTH (DEPTH),
    .PtrW  (PtrW)
  ) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (pop),
    .ptr     (rd_ptr)
  );

  // Storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= i;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign level = count_q;

  a_consume_needs_offer: assert property (@(posedge clk) disable iff (rst)
    !(i_consume && !i_hasAny));
  a_ready_needs_receiver: assert property (@(posedge clk) disable iff (rst)
    !(o_isReady && !o_canReceive));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_bus_fifo_tostd.sv
// Directed and randomised-stall checks for bus_fifo_tostd (DEPTH=3, 8-bit words, no bypass).
module tb_bus_fifo_tostd;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  typedef struct {
    logic         rst;
    logic         has;
    logic         rcv;
    logic [W-1:0] din;
    logic         e_cons;
    logic         e_rdy;
    logic         co;
    logic [W-1:0] e_o;
    logic [1:0]   e_lvl;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] i = '0;
  logic         i_hasAny = 1'b0;
  logic         i_consume;
  logic [W-1:0] o;
  logic         o_isReady;
  logic         o_canReceive = 1'b0;
  logic [1:0]   level;

  int n_vec = 0;
  int n_err = 0;

  bus_fifo_tostd #(
    .BusSize (W),
    .DEPTH   (D)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i            (i),
    .i_hasAny     (i_hasAny),
    .i_consume    (i_consume),
    .o            (o),
    .o_isReady    (o_isReady),
    .o_canReceive (o_canReceive),
    .level        (level)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic h, logic c, logic [W-1:0] d, logic ec,
                              logic er, logic co, logic [W-1:0] eo, logic [1:0] el);
    vec_t v;
    v.rst = r; v.has = h; v.rcv = c; v.din = d;
    v.e_cons = ec; v.e_rdy = er; v.co = co; v.e_o = eo; v.e_lvl = el;
    return v;
  endfunction

  // Drive after the falling edge, compare just before the next rising edge.
  task automatic apply(input vec_t v, input string name);
    logic bad;
    @(negedge clk);
    rst = v.rst; i_hasAny = v.has; o_canReceive = v.rcv; i = v.din;
    #1;
    bad = (i_consume !== v.e_cons) || (o_isReady !== v.e_rdy) || (level !== v.e_lvl) ||
          (v.co && (o !== v.e_o));
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL %s: consume=%b want %b, isReady=%b want %b, level=%0d want %0d, o=%h want %h",
               name, i_consume, v.e_cons, o_isReady, v.e_rdy, level, v.e_lvl, o,
               v.co ? v.e_o : o);
    end
  endtask

  vec_t vecs[$];
  vec_t mr[$];
  logic [W-1:0] mq[$];

  initial begin
    // Reset, held with an offer pending.
    vecs.push_back(mk(1, 1, 0, 8'h5A, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, 1, 1, 8'h5A, 0, 0, 0, 8'h00, 0));
    // Fill with consumer stalled: A,B,C taken, D refused.
    vecs.push_back(mk(0, 1, 0, 8'hA1, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'hB2, 1, 0, 1, 8'hA1, 1));
    vecs.push_back(mk(0, 1, 0, 8'hC3, 1, 0, 1, 8'hA1, 2));
    vecs.push_back(mk(0, 1, 0, 8'hD4, 0, 0, 1, 8'hA1, 3));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 8'hA1, 3));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 8'hB2, 2));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 8'hC3, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0));
    // Full while popping: push refused that cycle, accepted the next.
    vecs.push_back(mk(0, 1, 0, 8'h11, 1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 0, 8'h22, 1, 0, 1, 8'h11, 1));
    vecs.push_back(mk(0, 1, 0, 8'h33, 1, 0, 1, 8'h11, 2));
    vecs.push_back(mk(0, 1, 1, 8'h44, 0, 1, 1, 8'h11, 3));
    vecs.push_back(mk(0, 1, 1, 8'h44, 1, 1, 1, 8'h22, 2));
    vecs.push_back(mk(0, 1, 1, 8'h55, 1, 1, 1, 8'h33, 2));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 8'h44, 2));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 8'h55, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0));

    @(posedge clk);
    foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

    // Streaming 0..9: first output one cycle after first push, level held at 1.
    for (int k = 0; k < 12; k++) begin
      logic rdy;
      rdy = (k >= 1) && (k <= 10);
      apply(mk(0, k < 10, 1, W'(k), k < 10, rdy, rdy, W'(k - 1),
               ((k == 0) || (k == 11)) ? 2'd0 : 2'd1), $sformatf("stream%0d", k));
    end

    // Reset with two words buffered discards them; E is the next output.
    mr.push_back(mk(0, 1, 0, 8'h66, 1, 0, 0, 8'h00, 0));
    mr.push_back(mk(0, 1, 0, 8'h77, 1, 0, 1, 8'h66, 1));
    mr.push_back(mk(1, 1, 1, 8'h88, 0, 0, 0, 8'h00, 2));
    mr.push_back(mk(0, 1, 0, 8'hEE, 1, 0, 0, 8'h00, 0));
    mr.push_back(mk(0, 0, 1, 8'h00, 0, 1, 1, 8'hEE, 1));
    mr.push_back(mk(0, 0, 1, 8'h00, 0, 0, 0, 8'h00, 0));
    foreach (mr[k]) apply(mr[k], $sformatf("midrst%0d", k));

    // Random stalls on both sides against a queue model; 50 words through the wrap.
    begin
      int in_cnt = 0;
      int out_cnt = 0;
      int cyc = 0;
      while (out_cnt < 50 && cyc < 2000) begin
        logic has, rcv, ec, er;
        logic [W-1:0] word;
        has = (in_cnt < 50) && ($urandom_range(0, 3) != 0);
        rcv = ($urandom_range(0, 3) != 0);
        word = W'(in_cnt * 37 + 5);
        ec = has && (mq.size() < D);
        er = rcv && (mq.size() > 0);
        apply(mk(0, has, rcv, word, ec, er, er, er ? mq[0] : 8'h00, 2'(mq.size())),
              $sformatf("wrap%0d", cyc));
        if (er) begin
          void'(mq.pop_front());
          out_cnt++;
        end
        if (ec) begin
          mq.push_back(word);
          in_cnt++;
        end
        cyc++;
      end
      n_vec++;
      if (out_cnt != 50) begin
        n_err++;
        $display("FAIL wrap_budget: %0d words delivered, want 50", out_cnt);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
